// File: rtl/mod_alu.sv
// mod_alu: modular add / sub / mul for the ECDSA datapath. Runtime modulus p must be odd, > 2.
// Latency: done pulses in the cycle after edge N+1+K. K=1 for add/sub/reserved, K=WIDTH/DIGIT for mul.
// Backpressure: none. start is taken only in IDLE while done is low, and is dropped otherwise.
// Ports: clk, rst (async, active-high); start/op/a/b/p request; busy, done, result, err response.
// Optional: define MOD_ALU_RANGE_CHECK_EN to force err on a>=p or b>=p (takes the EXEC path, no mul).
module mod_alu #(
  parameter int WIDTH = 256,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] p,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

  state_t           state;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, p_q;
  logic [WIDTH+1:0] acc;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] r_q;
  logic             e_q;

  // One interleaved sub-step: double, reduce, conditionally add a, reduce.
  // acc < p on entry keeps every intermediate below 2p, so WIDTH+2 bits suffice.
  function automatic logic [WIDTH+1:0] mstep(input logic [WIDTH+1:0] acc_in,
                                             input logic             bit_in,
                                             input logic [WIDTH+1:0] aw,
                                             input logic [WIDTH+1:0] pw);
    logic [WIDTH+1:0] t;
    t = acc_in << 1;
    if (t >= pw) t = t - pw;
    if (bit_in) begin
      t = t + aw;
      if (t >= pw) t = t - pw;
    end
    return t;
  endfunction

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] exec_r;
  logic             exec_e;
  logic [WIDTH+1:0] mul_next;

  // Add/sub reductions: the low WIDTH bits of s-p and a-b+p are exact under
  // mod 2^WIDTH arithmetic, because the true results always lie in [0, p-1].
  always_comb begin
    sum    = {1'b0, a_q} + {1'b0, b_q};
    exec_r = '0;
    exec_e = 1'b0;
    case (op_q)
      2'b00:   exec_r = (sum >= {1'b0, p_q}) ? (sum[WIDTH-1:0] - p_q) : sum[WIDTH-1:0];
      2'b01:   exec_r = (a_q >= b_q) ? (a_q - b_q) : (a_q - b_q + p_q);
      default: begin
        exec_r = '0;
        exec_e = 1'b1;
      end
    endcase
  end

  // DIGIT sub-steps per cycle. b_q is shifted left each cycle, so the current
  // multiplier bits always sit at the top.
  always_comb begin
    mul_next = acc;
    for (int k = 0; k < DIGIT; k++) begin
      mul_next = mstep(mul_next, b_q[WIDTH-1-k], {2'b00, a_q}, {2'b00, p_q});
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      op_q   <= 2'b00;
      a_q    <= '0;
      b_q    <= '0;
      p_q    <= '0;
      acc    <= '0;
      idx    <= '0;
      r_q    <= '0;
      e_q    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          // done is still high during the pulse cycle, so a start landing
          // there is dropped and busy stays high through that cycle.
          if (start && !done) begin
            a_q  <= a;
            b_q  <= b;
            p_q  <= p;
            op_q <= op;
            busy <= 1'b1;
`ifdef MOD_ALU_RANGE_CHECK_EN
            if (a >= p || b >= p) begin
              op_q  <= 2'b11;
              state <= EXEC;
            end else
`endif
            if (op == 2'b10) begin
              acc   <= '0;
              idx   <= IW'(WIDTH - 1);
              state <= MUL;
            end else begin
              state <= EXEC;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        EXEC: begin
          r_q   <= exec_r;
          e_q   <= exec_e;
          state <= DONE;
        end
        MUL: begin
          acc <= mul_next;
          b_q <= b_q << DIGIT;
          idx <= idx - IW'(DIGIT);
          if (idx == IW'(DIGIT - 1)) begin
            r_q   <= mul_next[WIDTH-1:0];
            e_q   <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          done   <= 1'b1;
          result <= r_q;
          err    <= e_q;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mod_alu.md
Name: mod_alu

Overview:
- Parametrised modular arithmetic unit for the ECDSA datapath, the successor building block beneath point_add.
- Computes (a+b) mod p, (a−b) mod p or (a·b) mod p for a runtime modulus p with a start/done handshake.
- Operand width and multiplier digit size are generic, so the same unit serves secp256k1 (256-bit) and narrower test curves.
- The multiply is bit-serial interleaved, MSB first, with DIGIT bits consumed per cycle.

Parameters:
- WIDTH, 256, operand, modulus and result width in bits.
- DIGIT, 1, multiplier bits consumed per MUL cycle; legal values are 1 or 2; WIDTH must be divisible by DIGIT.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- op  input  2  operation: 00 add, 01 sub, 10 mul, 11 reserved.
- a  input  WIDTH  operand A, latched on accepted start.
- b  input  WIDTH  operand B (multiplier for mul), latched on accepted start.
- p  input  WIDTH  modulus, latched on accepted start; must be odd and greater than 2.
- busy  output  1  high from the cycle after an accepted start through the DONE cycle.
- done  output  1  one-cycle pulse; result and err are valid in that cycle.
- result  output  WIDTH  result, held until the next accepted start.
- err  output  1  error flag, valid with done and held with result.

Behaviour:
- Reset, asynchronous and any time including mid-operation:
  - state returns to IDLE.
  - busy, done, result and err all clear to 0.
  - any in-flight operation is discarded.
- States: IDLE, EXEC, MUL, DONE.
- IDLE with start=1 at edge N:
  - latch a, b, p and op.
  - op 00, 01 or 11 go to EXEC; op 10 goes to MUL and loads acc=0, bit index=WIDTH−1.
- EXEC, one cycle:
  - add: s=a+b at WIDTH+1 bits; r = s−p if s≥p, else s.
  - sub: r = a−b if a≥b, else a−b+p, computed on the WIDTH+1-bit intermediate.
  - op 11: r=0 and err=1.
  - go to DONE.
- MUL, WIDTH/DIGIT cycles, each applying DIGIT sub-steps in order:
  - acc = 2·acc, minus p if the result is ≥p.
  - if b[idx]=1: acc = acc+a, minus p if the result is ≥p.
  - idx decrements per sub-step.
  - internal width is WIDTH+2 bits; no overflow is allowed.
  - after the last digit, go to DONE.
- DONE, one cycle:
  - done=1; result and err registered; next state is IDLE.
- Latency: done is high in the cycle after edge N+1+K, where K=1 for add/sub/reserved and K=WIDTH/DIGIT for mul.
  - WIDTH=256, DIGIT=1: mul done at N+257; add done at N+2.
- Back-to-back: a start asserted during the DONE cycle is ignored. A new start is accepted in IDLE on the next edge.
- start asserted while busy is ignored, with no queuing.
- Input changes after acceptance have no effect.
- Operand precondition: a<p and b<p. Results for out-of-range operands are unspecified unless MOD_ALU_RANGE_CHECK_EN is defined.
- Results are always fully reduced to [0, p−1] for in-range operands.
- err is 0 for every legal op.

Optional Feature:
- Macro MOD_ALU_RANGE_CHECK_EN.
- Defined:
  - on accepted start, if a≥p or b≥p, the unit takes the EXEC path regardless of op.
  - done comes after K=1 with result=0 and err=1.
  - the multiply is skipped.
- Undefined:
  - no comparators are built; err only flags op 11.
  - out-of-range behaviour is unspecified.

Test Plan:
- Test modulus is p = secp256k1 prime FFFF…FFFEFFFFFC2F, i.e. 2^256−0x1000003D1.
- Reset: assert rst mid-MUL (cycle 100) -> busy, done, result and err read 0 asynchronously; a subsequent add completes normally.
- Add wrap: a=p−1, b=2, op=00 -> result=1, err=0, done exactly 2 cycles after start edge.
- Sub borrow: a=0, b=1, op=01 -> result=p−1 (…FFFEFFFFFC2E).
- Mul: a=2, b=p−1 -> result=p−2. Also a=b=2^128 -> result=0x1000003D1. Both with done at N+257 for DIGIT=1 and N+129 for DIGIT=2.
- Handshake: pulse start during busy with different operands -> ignored, first result unchanged. op=11 -> err=1, result=0. result holds after done until the next start.
- MOD_ALU_RANGE_CHECK_EN defined: a=p, b=1, op=10 -> done at N+2, err=1, result=0. With the macro undefined, err stays 0 for legal ops.
